fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_stream_reader_if.sv | 20 ++
 rtl/fifo_skid_buf.sv | 64 ++++++
 rtl/fifo_stream_reader.sv | 61 ++++++
 tb/tb_fifo_stream_reader.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO stream reader and its output buffer.
package fifo_pkg;

  localparam int DATA_W_DEF = 128;
  localparam int CNT_W_DEF  = 32;
  localparam int BUF_DEPTH  = 2;

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_FULL  = 2'd2;

  // Buffer level after this cycle if no new read is issued (push from infl minus pop).
  function automatic logic [2:0] fill_level(occ_t occ, logic infl, logic pop);
    return {1'b0, occ} + {2'b0, infl} - {2'b0, pop};
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Connection between the read controller and its 2-entry output buffer.
interface fifo_stream_reader_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  // push writes push_data at the tail this cycle; pop removes the head this
  // cycle (ignored when empty); flush empties the buffer and wins over both.
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              pop;
  logic              flush;
  occ_t              occ;
  logic [DATA_W-1:0] head_data;

  modport master (output push, push_data, pop, flush, input occ, head_data);
  modport slave  (input push, push_data, pop, flush, output occ, head_data);

endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order output buffer: head feeds the stream, tail absorbs the word in flight.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input logic                 clk,
  input logic                 rst,
  fifo_stream_reader_if.slave sb
);

  occ_t              occ_q, occ_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic              do_pop;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    do_pop = sb.pop && (occ_q != OCC_EMPTY);
    if (sb.flush) begin
      occ_d = OCC_EMPTY;
    end else begin
      case ({sb.push, do_pop})
        2'b10: begin
          if (occ_q == OCC_EMPTY) head_d = sb.push_data;
          else                    tail_d = sb.push_data;
          if (occ_q != OCC_FULL)  occ_d  = occ_q + 2'd1;
        end
        2'b01: begin
          head_d = tail_q;
          occ_d  = occ_q - 2'd1;
        end
        2'b11: begin
          // Level unchanged; with two entries the tail advances to head.
          if (occ_q == OCC_FULL) begin
            head_d = tail_q;
            tail_d = sb.push_data;
          end else begin
            head_d = sb.push_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= OCC_EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign sb.occ       = occ_q;
  assign sb.head_data = head_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads a 1-cycle-latency FIFO and presents its words as a valid/ready stream.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_rden,
  input  logic [DATA_W-1:0] i_rddata,
  input  logic              i_empty,
  input  logic              i_flush,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready,
  output logic [CNT_W-1:0]  o_wcnt
);

  fifo_stream_reader_if #(.DATA_W(DATA_W)) sb ();

  logic             infl_q, infl_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             pop;

  assign o_valid = (sb.occ != OCC_EMPTY);
  assign o_data  = sb.head_data;
  assign pop     = o_valid && i_ready;

  // A read is issued only if its word is guaranteed a free slot on arrival.
  always_comb begin
    o_rden = 1'b0;
    if (!rst && !i_empty && !i_flush && (fill_level(sb.occ, infl_q, pop) < 3'd2))
      o_rden = 1'b1;
    infl_d = o_rden;
    wcnt_d = pop ? wcnt_q + CNT_W'(1) : wcnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      infl_q <= 1'b0;
      wcnt_q <= '0;
    end else begin
      infl_q <= infl_d;
      wcnt_q <= wcnt_d;
    end
  end

  assign sb.push      = infl_q && !i_flush;
  assign sb.push_data = i_rddata;
  assign sb.pop       = pop;
  assign sb.flush     = i_flush;
  assign o_wcnt       = wcnt_q;

  fifo_skid_buf #(.DATA_W(DATA_W)) u_buf (
    .clk (clk),
    .rst (rst),
    .sb  (sb)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO stub, queue-based stream model, directed and random traffic.
module tb_fifo_stream_reader;

  localparam int DW = 32;
  localparam int CW = 4;

  typedef struct {
    logic          ready;
    logic          exp_rden;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic [CW-1:0] exp_wcnt;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          o_rden;
  logic [DW-1:0] i_rddata;
  logic          i_empty;
  logic          i_flush;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          i_ready;
  logic [CW-1:0] o_wcnt;

  // clock / reset block
  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .o_rden   (o_rden),
    .i_rddata (i_rddata),
    .i_empty  (i_empty),
    .i_flush  (i_flush),
    .o_valid  (o_valid),
    .o_data   (o_data),
    .i_ready  (i_ready),
    .o_wcnt   (o_wcnt)
  );

  int            n_chk  = 0;
  int            n_pass = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  logic          m_infl = 1'b0;
  logic [DW-1:0] m_infl_data = '0;
  logic [CW-1:0] m_cnt = '0;
  logic          dut_rden_s = 1'b0;
  vec_t          tbl[6];
  int            rden_seen;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic add_word(logic [DW-1:0] w);
    fifo_q.push_back(w);
    i_empty = 1'b0;
  endtask

  // Mid-cycle: compare outputs against the model, then advance the model.
  task automatic at_neg();
    logic pop, exp_rden;
    int   lvl;
    @(negedge clk);
    pop      = (exp_q.size() > 0) && (i_ready === 1'b1);
    lvl      = exp_q.size() + (m_infl ? 1 : 0) - (pop ? 1 : 0);
    exp_rden = (rst !== 1'b1) && (fifo_q.size() > 0) && (i_flush !== 1'b1) && (lvl < 2);
    chk("rden", 64'(o_rden), 64'(exp_rden));
    chk("valid", 64'(o_valid), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0) chk("data", 64'(o_data), 64'(exp_q[0]));
    chk("wcnt", 64'(o_wcnt), 64'(m_cnt));
    dut_rden_s = o_rden;
    if (o_valid === 1'b1 && i_ready === 1'b1) got_q.push_back(o_data);
    if (rst === 1'b1) begin
      exp_q.delete();
      m_infl = 1'b0;
      m_cnt  = '0;
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        m_cnt++;
      end
      if (i_flush === 1'b1) exp_q.delete();
      else if (m_infl) exp_q.push_back(m_infl_data);
      m_infl = exp_rden;
      if (exp_rden) m_infl_data = fifo_q[0];
    end
  endtask

  // FIFO stub: data for a read appears one cycle after o_rden.
  task automatic to_pos();
    @(posedge clk);
    #1;
    if (dut_rden_s === 1'b1 && fifo_q.size() > 0) i_rddata = fifo_q.pop_front();
    else i_rddata = $urandom;
    i_empty = (fifo_q.size() == 0);
  endtask

  task automatic step();
    at_neg();
    to_pos();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0, 4'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h0, 4'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h1, 4'd0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 32'h2, 4'd1};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 32'h3, 4'd2};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 32'h0, 4'd3};

    rst      = 1'b1;
    i_ready  = 1'b0;
    i_flush  = 1'b0;
    i_empty  = 1'b1;
    i_rddata = '0;
    add_word(32'h1);
    add_word(32'h2);
    add_word(32'h3);
    @(posedge clk);
    #1;
    // reset held with a non-empty FIFO: nothing may be read
    run(2);
    at_neg();
    chk("rst_data", 64'(o_data), 64'h0);
    chk("rst_occ", 64'(dut.sb.occ), 64'h0);
    chk("rst_infl", 64'(dut.infl_q), 64'h0);
    to_pos();
    rst = 1'b0;

    // preloaded 1,2,3 with ready high
    for (int i = 0; i < 6; i++) begin
      i_ready = tbl[i].ready;
      at_neg();
      chk($sformatf("tbl%0d_rden", i), 64'(o_rden), 64'(tbl[i].exp_rden));
      chk($sformatf("tbl%0d_valid", i), 64'(o_valid), 64'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) chk($sformatf("tbl%0d_data", i), 64'(o_data), 64'(tbl[i].exp_data));
      chk($sformatf("tbl%0d_wcnt", i), 64'(o_wcnt), 64'(tbl[i].exp_wcnt));
      to_pos();
    end

    // backpressure: 4 words, ready low for 5 cycles
    got_q.delete();
    for (int i = 0; i < 4; i++) add_word(32'hA0 + 32'(i));
    i_ready = 1'b0;
    run(5);
    at_neg();
    chk("bp_occ", 64'(dut.sb.occ), 64'h2);
    chk("bp_rden", 64'(o_rden), 64'h0);
    chk("bp_data", 64'(o_data), 64'hA0);
    to_pos();
    i_ready = 1'b1;
    run(8);
    chk("bp_cnt", 64'(got_q.size()), 64'h4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      chk($sformatf("bp_word%0d", i), 64'(got_q[i]), 64'(32'hA0 + 32'(i)));

    // empty FIFO throughout
    rden_seen = 0;
    for (int i = 0; i < 10; i++) begin
      i_ready = 1'($urandom_range(0, 1));
      at_neg();
      if (o_rden === 1'b1) rden_seen++;
      to_pos();
    end
    chk("empty_rden", 64'(rden_seen), 64'h0);
    chk("empty_valid", 64'(o_valid), 64'h0);

    // flush with one buffered word and one in flight
    got_q.delete();
    add_word(32'hB0);
    add_word(32'hB1);
    add_word(32'hB2);
    i_ready = 1'b0;
    run(2);
    i_flush = 1'b1;
    at_neg();
    chk("fl_occ", 64'(dut.sb.occ), 64'h1);
    chk("fl_infl", 64'(dut.infl_q), 64'h1);
    chk("fl_rden", 64'(o_rden), 64'h0);
    to_pos();
    i_flush = 1'b0;
    at_neg();
    chk("fl_valid", 64'(o_valid), 64'h0);
    chk("fl_rden2", 64'(o_rden), 64'h1);
    to_pos();
    step();
    at_neg();
    chk("fl_relat_valid", 64'(o_valid), 64'h1);
    chk("fl_relat_data", 64'(o_data), 64'hB2);
    to_pos();
    i_ready = 1'b1;
    run(4);
    chk("fl_got_cnt", 64'(got_q.size()), 64'h1);
    if (got_q.size() > 0) chk("fl_got_word", 64'(got_q[0]), 64'hB2);

    // reset while the buffer is full
    got_q.delete();
    for (int i = 0; i < 4; i++) add_word(32'hC0 + 32'(i));
    i_ready = 1'b0;
    run(4);
    chk("rs_occ", 64'(dut.sb.occ), 64'h2);
    rst = 1'b1;
    step();
    at_neg();
    chk("rs_valid", 64'(o_valid), 64'h0);
    chk("rs_data", 64'(o_data), 64'h0);
    chk("rs_wcnt", 64'(o_wcnt), 64'h0);
    chk("rs_rden", 64'(o_rden), 64'h0);
    to_pos();
    rst = 1'b0;
    i_ready = 1'b1;
    run(8);
    chk("rs_got_cnt", 64'(got_q.size()), 64'h2);
    if (got_q.size() == 2) begin
      chk("rs_word0", 64'(got_q[0]), 64'hC2);
      chk("rs_word1", 64'(got_q[1]), 64'hC3);
    end

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) add_word($urandom);
      i_ready = ($urandom_range(0, 3) != 0);
      i_flush = ($urandom_range(0, 19) == 0);
      rst     = ($urandom_range(0, 199) == 0);
      step();
    end
    rst     = 1'b0;
    i_flush = 1'b0;
    i_ready = 1'b1;
    run(40);

    // counter wrap: 17 transfers with a 4-bit counter
    got_q.delete();
    fifo_q.delete();
    i_empty = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 17; i++) add_word(32'h100 + 32'(i));
    run(25);
    chk("wrap_got", 64'(got_q.size()), 64'd17);
    chk("wrap_wcnt", 64'(o_wcnt), 64'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
